// File: rtl/carousel_rotator.sv
// N-channel carousel: per-channel fill handshake, left rotation by rot_amt, per-channel drain.
// Optional CAROUSEL_ROUND_COUNT_EN adds round_count and rot_overflow outputs.
module carousel_rotator #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROT_W      = ($clog2(NUM_CH + 1) > 1) ? $clog2(NUM_CH + 1) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            data_in_valid,
    output logic [NUM_CH-1:0]            data_in_ready,
    input  logic [ROT_W-1:0]             rot_amt,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            data_out_valid,
    input  logic [NUM_CH-1:0]            data_out_ready,
    output logic                         busy
`ifdef CAROUSEL_ROUND_COUNT_EN
    ,
    output logic [31:0]                  round_count,
    output logic                         rot_overflow
`endif
);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_ROTATE,
        ST_DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_CH-1:0]       full_q, full_d;
    logic [DATA_WIDTH-1:0]   slot_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   slot_d [NUM_CH];
    logic [ROT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0]       accept;
    logic [NUM_CH-1:0]       xfer;
    logic                    fill_done;
    logic                    drain_done;

    // Ready depends only on registers and rst, never on data_in_valid.
    always_comb begin
        data_in_ready  = (state_q == ST_FILL && !rst) ? ~full_q : '0;
        data_out_valid = (state_q == ST_DRAIN) ? full_q : '0;
        busy           = (state_q != ST_FILL);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
    end

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        fill_done  = 1'b0;
        drain_done = 1'b0;
        accept     = data_in_valid & data_in_ready;
        xfer       = data_out_valid & data_out_ready;
        case (state_q)
            ST_FILL: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (accept[i]) begin
                        slot_d[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                full_d = full_q | accept;
                if (&full_d) begin
                    fill_done = 1'b1;
                    cnt_d     = rot_amt;
                    state_d   = (rot_amt == '0) ? ST_DRAIN : ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    slot_d[i] = slot_q[(i + 1) % NUM_CH];
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == ROT_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                full_d = full_q & ~xfer;
                if (full_d == '0) begin
                    drain_done = 1'b1;
                    state_d    = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            full_q  <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

`ifdef CAROUSEL_ROUND_COUNT_EN
    logic [31:0] round_count_q;
    logic        rot_overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_count_q  <= '0;
            rot_overflow_q <= 1'b0;
        end else begin
            if (drain_done) begin
                round_count_q <= round_count_q + 32'd1;
            end
            if (fill_done) begin
                rot_overflow_q <= (32'(rot_amt) >= NUM_CH);
            end
        end
    end

    assign round_count  = round_count_q;
    assign rot_overflow = rot_overflow_q;
`else
    logic unused_flags;
    assign unused_flags = fill_done ^ drain_done;
`endif

endmodule

// File: tb/tb_carousel_rotator.sv
// Bench for carousel_rotator: directed test-plan sequences plus random traffic,
// all checked every cycle against a round-level model of the carousel.
module tb_carousel_rotator;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int RW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   data_in_valid;
    logic [N-1:0]   data_in_ready;
    logic [RW-1:0]  rot_amt;
    logic [N*W-1:0] data_out;
    logic [N-1:0]   data_out_valid;
    logic [N-1:0]   data_out_ready;
    logic           busy;
`ifdef CAROUSEL_ROUND_COUNT_EN
    logic [31:0]    round_count;
    logic           rot_overflow;
`endif

    always #5 clk = ~clk;

    carousel_rotator #(.NUM_CH(N), .DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .rot_amt        (rot_amt),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .busy           (busy)
`ifdef CAROUSEL_ROUND_COUNT_EN
        ,
        .round_count    (round_count),
        .rot_overflow   (rot_overflow)
`endif
    );

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-level model: words captured at fill, then viewed rotated by rot_done positions.
    int          m_phase;      // 0 fill, 1 rotating, 2 draining
    logic [N-1:0] m_full;
    logic [W-1:0] m_cap [N];
    int          m_rot_done;
    int          m_rot_total;
    logic [31:0] m_rc;
    logic        m_ovf;

    always @(posedge clk or posedge rst) begin : model
        logic [N-1:0] nf;
        if (rst) begin
            m_phase     <= 0;
            m_full      <= '0;
            m_rot_done  <= 0;
            m_rot_total <= 0;
            m_rc        <= '0;
            m_ovf       <= 1'b0;
            for (int i = 0; i < N; i++) m_cap[i] <= '0;
        end else begin
            case (m_phase)
                0: begin
                    nf = m_full;
                    for (int i = 0; i < N; i++) begin
                        if (data_in_valid[i] && !m_full[i]) begin
                            m_cap[i] <= data_in[i*W +: W];
                            nf[i] = 1'b1;
                        end
                    end
                    m_full <= nf;
                    if (&nf) begin
                        m_rot_total <= int'(rot_amt);
                        m_rot_done  <= 0;
                        m_phase     <= (rot_amt == 0) ? 2 : 1;
                        m_ovf       <= (int'(rot_amt) >= N);
                    end
                end
                1: begin
                    m_rot_done <= m_rot_done + 1;
                    if (m_rot_done + 1 >= m_rot_total) m_phase <= 2;
                end
                default: begin
                    nf = m_full & ~data_out_ready;
                    m_full <= nf;
                    if (nf == '0) begin
                        m_phase    <= 0;
                        m_rot_done <= 0;
                        m_rc       <= m_rc + 32'd1;
                        for (int i = 0; i < N; i++) m_cap[i] <= m_cap[(i + m_rot_done) % N];
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic [N*W-1:0] e_dout;
        logic [N-1:0]   e_rdy;
        logic [N-1:0]   e_vld;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                e_dout[i*W +: W] = m_cap[(i + m_rot_done) % N];
                e_rdy[i] = (m_phase == 0) && !m_full[i] && !rst;
                e_vld[i] = (m_phase == 2) && m_full[i];
            end
            check("cyc_data_out", 32'(data_out), 32'(e_dout));
            check("cyc_in_ready", 32'(data_in_ready), 32'(e_rdy));
            check("cyc_out_valid", 32'(data_out_valid), 32'(e_vld));
            check("cyc_busy", 32'(busy), 32'(m_phase != 0));
`ifdef CAROUSEL_ROUND_COUNT_EN
            check("cyc_round_count", round_count, m_rc);
            check("cyc_rot_overflow", 32'(rot_overflow), 32'(m_ovf));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        data_in        = '0;
        data_in_valid  = '0;
        data_out_ready = '0;
        rot_amt        = '0;
        tick();
        tick();
        check("rst_ready", 32'(data_in_ready), 32'h0);
        check("rst_valid", 32'(data_out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_data", 32'(data_out), 32'h0);
        rst    = 1'b0;
        chk_en = 1'b1;
        #1;
        check("post_rst_ready", 32'(data_in_ready), 32'h7);

        // 1: rot_amt=1
        data_in = {8'h33, 8'h22, 8'h11}; data_in_valid = 3'b111; rot_amt = 2'd1;
        tick();
        data_in_valid = '0;
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_valid_rot", 32'(data_out_valid), 32'h0);
        tick();
        check("t1_data", 32'(data_out), 32'h113322);
        check("t1_valid", 32'(data_out_valid), 32'h7);
        data_out_ready = 3'b111;
        tick();
        data_out_ready = '0;
        check("t1_ready_back", 32'(data_in_ready), 32'h7);

        // 2: rot_amt=0
        data_in_valid = 3'b111; rot_amt = 2'd0;
        tick();
        data_in_valid = '0;
        check("t2_valid", 32'(data_out_valid), 32'h7);
        check("t2_data", 32'(data_out), 32'h332211);
        data_out_ready = 3'b111;
        tick();
        data_out_ready = '0;

        // 3: rot_amt=3 restores order
        data_in_valid = 3'b111; rot_amt = 2'd3;
        tick();
        data_in_valid = '0;
        tick();
        tick();
        check("t3_still_rot", 32'(data_out_valid), 32'h0);
        check("t3_busy", 32'(busy), 32'h1);
        tick();
        check("t3_valid", 32'(data_out_valid), 32'h7);
        check("t3_data", 32'(data_out), 32'h332211);
`ifdef CAROUSEL_ROUND_COUNT_EN
        check("t3_overflow", 32'(rot_overflow), 32'h1);
`endif
        data_out_ready = 3'b111;
        tick();
        data_out_ready = '0;

        // 4: staggered fill, held valid on a full slot is ignored
        data_in = {8'h00, 8'hA5, 8'h00}; data_in_valid = 3'b010; rot_amt = 2'd0;
        tick();
        check("t4_ready_101", 32'(data_in_ready), 32'h5);
        data_in = {8'h00, 8'hFF, 8'h00};
        tick(); tick(); tick();
        check("t4_ready_hold", 32'(data_in_ready), 32'h5);
        check("t4_slot1", 32'(data_out[15:8]), 32'hA5);
        data_in = {8'h03, 8'hFF, 8'h01}; data_in_valid = 3'b111;
        tick();
        data_in_valid = '0;
        check("t4_valid", 32'(data_out_valid), 32'h7);
        check("t4_data", 32'(data_out), 32'h03A501);

        // 5: drain backpressure on ch2
        data_out_ready = 3'b011;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_valid", 32'(data_out_valid), 32'h4);
            check("t5_ready", 32'(data_in_ready), 32'h0);
            check("t5_ch2", 32'(data_out[23:16]), 32'h03);
        end
        data_out_ready = 3'b111;
        tick();
        data_out_ready = '0;
        check("t5_valid_done", 32'(data_out_valid), 32'h0);
        check("t5_ready_back", 32'(data_in_ready), 32'h7);
`ifdef CAROUSEL_ROUND_COUNT_EN
        check("t5_round_count", round_count, 32'd4);
`endif

        // 6: reset in the second ROTATE cycle
        data_in = {8'h33, 8'h22, 8'h11}; data_in_valid = 3'b111; rot_amt = 2'd3;
        tick();
        data_in_valid = '0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(data_out_valid), 32'h0);
        check("t6_ready", 32'(data_in_ready), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_data", 32'(data_out), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_ready_back", 32'(data_in_ready), 32'h7);
        data_in = {8'h03, 8'h02, 8'h01}; data_in_valid = 3'b111; rot_amt = 2'd0;
        tick();
        data_in_valid = '0;
        check("t6_refill", 32'(data_out), 32'h030201);
        check("t6_refill_valid", 32'(data_out_valid), 32'h7);
        data_out_ready = 3'b111;
        tick();
        data_out_ready = '0;
`ifdef CAROUSEL_ROUND_COUNT_EN
        check("t6_round_count", round_count, 32'd1);
`endif

        // Random traffic, checked by the per-cycle compare against the model
        for (int k = 0; k < 500; k++) begin
            data_in        = N*W'($urandom);
            data_in_valid  = N'($urandom);
            data_out_ready = N'($urandom);
            rot_amt        = RW'($urandom_range(0, 3));
            tick();
        end

        data_in_valid  = '0;
        data_out_ready = '0;
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
